uart_tx_serializer: RTL and testbench

//  UART transmit serializer, directly downstream of the FIFO selector.

---
 rtl/uart_tx_serializer_if.sv | 32 +++
 rtl/uart_tx_serializer.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Bundles the selector-facing and line-facing signals of the UART transmit serializer.
// master: the side that supplies bytes and ticks; slave: the serializer itself.
interface uart_tx_serializer_if #(
   parameter int unsigned DATA_BITS = 8
);

   logic                 s_tick;
   logic [DATA_BITS-1:0] data;
   logic                 not_empty;
   logic                 tx;
   logic                 tx_done;
   logic                 busy;

   modport master (
      output s_tick,
      output data,
      output not_empty,
      input  tx,
      input  tx_done,
      input  busy
   );

   modport slave (
      input  s_tick,
      input  data,
      input  not_empty,
      output tx,
      output tx_done,
      output busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches one byte from the FIFO selector and shifts it out LSB-first
// as a start/data/(parity)/stop frame timed by the 16x oversampling tick. tx_done pulses once per
// frame and doubles as the selector pop; a short HOLD phase afterwards covers the selector's
// pop latency so the byte just sent is not picked up again.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned SB_TICK   = 16,
   parameter int unsigned HOLDOFF   = 3
) (
   input logic                 clk,
   input logic                 rst,
   uart_tx_serializer_if.slave bus
);

   // Tick counter must also reach SB_TICK-1 for 1.5/2 stop-bit settings.
   localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [SW-1:0] BitLast  = SW'(15);
   localparam logic [SW-1:0] StopLast = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] DataLast = NW'(DATA_BITS - 1);
   localparam logic [HW-1:0] HoldLast = HW'(HOLDOFF - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop,
      StHold
   } state_e;

   state_e               state_q, state_d;
   logic [SW-1:0]        s_q, s_d;
   logic [NW-1:0]        n_q, n_d;
   logic [HW-1:0]        h_q, h_d;
   logic [DATA_BITS-1:0] b_q, b_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         s_q     <= '0;
         n_q     <= '0;
         h_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         h_q     <= h_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state, counter updates, and output values derived from the state being entered.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      h_d     = h_q;
      b_d     = b_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      unique case (state_q)
         StIdle: begin
            // Start does not wait for a tick; the byte is latched exactly once here.
            if (bus.not_empty) begin
               b_d     = bus.data;
               s_d     = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = ^bus.data;
`endif
               state_d = StStart;
            end
         end
         StStart: begin
            if (bus.s_tick) begin
               if (s_q == BitLast) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = StData;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         StData: begin
            if (bus.s_tick) begin
               if (s_q == BitLast) begin
                  b_d = b_q >> 1;
                  s_d = '0;
                  if (n_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bus.s_tick) begin
               if (s_q == BitLast) begin
                  s_d     = '0;
                  state_d = StStop;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
`endif
         StStop: begin
            if (bus.s_tick) begin
               if (s_q == StopLast) begin
                  s_d     = '0;
                  h_d     = '0;
                  done_d  = 1'b1;
                  state_d = StHold;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         StHold: begin
            // Counts raw clocks so the holdoff tracks the selector's pop latency, not baud.
            if (h_q == HoldLast) begin
               state_d = StIdle;
            end else begin
               h_d = h_q + HW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      tx_d = 1'b1;
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != StIdle);
   end

   assign bus.tx      = tx_q;
   assign bus.tx_done = done_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer. Inputs change and outputs are sampled on
// the falling clock edge; a small frame receiver decodes tx by counting s_tick pulses.
module tb_uart_tx_serializer;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned HOLDOFF   = 3;
`ifdef UART_TX_PARITY_EN
   localparam int NB    = DATA_BITS + 3;
   localparam int FRAME = 176;
`else
   localparam int NB    = DATA_BITS + 2;
   localparam int FRAME = 160;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_serializer_if #(.DATA_BITS(DATA_BITS)) bus ();

   uart_tx_serializer #(
      .DATA_BITS(DATA_BITS),
      .SB_TICK  (16),
      .HOLDOFF  (HOLDOFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc_n        = 0;
   int   tick_div     = 1;
   int   tick_cnt     = 0;
   int   stall_start  = 0;
   int   stall_len    = 0;
   bit   churn        = 1'b0;
   bit   ne_pulse     = 1'b0;
   logic last_tick    = 1'b0;

   // Advance one clock; record whether the edge just passed carried a tick, then set up inputs.
   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      last_tick = bus.s_tick;
      tick_cnt  = (tick_cnt + 1) % tick_div;
      if (cyc_n >= stall_start && cyc_n < stall_start + stall_len) bus.s_tick = 1'b0;
      else bus.s_tick = (tick_cnt == 0);
      if (ne_pulse) begin
         bus.not_empty = 1'b0;
         ne_pulse      = 1'b0;
      end
      if (churn) begin
         if (bus.busy === 1'b1) begin
            bus.data      = 8'($urandom);
            bus.not_empty = 1'($urandom_range(0, 1));
         end else begin
            bus.not_empty = 1'b0;
         end
      end
   endtask

   // Waits for a start bit, then samples every bit over 16 ticks. Returns raw observations only.
   task automatic rx_frame(output logic [NB-1:0] bits, output bit uniform, output int start_wait,
                           output int done_clks, output int done_cnt, output bit timeout);
      int   clks;
      int   g;
      bit   started;
      logic first;
      bits       = '0;
      uniform    = 1'b1;
      start_wait = 0;
      done_clks  = -1;
      done_cnt   = 0;
      timeout    = 1'b0;
      started    = 1'b0;
      clks       = 0;
      while (!started && !timeout) begin
         cyc();
         start_wait++;
         if (bus.tx_done === 1'b1) done_cnt++;
         if (bus.tx === 1'b0) started = 1'b1;
         else if (start_wait >= 6000) timeout = 1'b1;
      end
      for (int i = 0; i < NB && !timeout; i++) begin
         first   = bus.tx;
         bits[i] = first;
         for (int k = 0; k < 16 && !timeout; k++) begin
            g = 0;
            do begin
               if (bus.tx !== first) uniform = 1'b0;
               cyc();
               clks++;
               g++;
               if (bus.tx_done === 1'b1) begin
                  done_cnt++;
                  done_clks = clks;
               end
               if (g >= 300) timeout = 1'b1;
            end while (last_tick !== 1'b1 && !timeout);
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1;
      bus.data = '0;
      bus.not_empty = 1'b0;
      bus.s_tick = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      tests_run++;
      if (bus.tx !== 1'b1) begin
         tests_failed++; $display("FAIL reset_tx got %b want 1", bus.tx);
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy);
      end
      tests_run++;
      if (bus.tx_done !== 1'b0) begin
         tests_failed++; $display("FAIL reset_done got %b want 0", bus.tx_done);
      end
      // Start a frame, then reset it while in the start bit.
      bus.data = 8'hA5;
      bus.not_empty = 1'b1;
      ne_pulse = 1'b1;
      cyc();
      tests_run++;
      if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
         tests_failed++; $display("FAIL start_bit got tx=%b busy=%b want tx=0 busy=1", bus.tx, bus.busy);
      end
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      tests_run++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midframe_reset got tx=%b busy=%b done=%b want 1 0 0", bus.tx, bus.busy, bus.tx_done);
      end
      cyc();
      rst = 1'b0;
      bad = 0;
      repeat (200) begin
         cyc();
         if (bus.tx_done !== 1'b0 || bus.tx !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL post_reset_quiet got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_single_byte();
      logic [NB-1:0] bits, exp;
      bit uni, tmo;
      int sw, dclk, dcnt, bad;
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
      exp = {1'b1, 8'hA5, 1'b0};
`endif
      tick_div = 1;
      bus.data = 8'hA5;
      bus.not_empty = 1'b1;
      ne_pulse = 1'b1;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      tests_run++;
      if (tmo !== 1'b0) begin
         tests_failed++; $display("FAIL single_timeout got %b want 0", tmo);
      end
      tests_run++;
      if (bits !== exp) begin
         tests_failed++; $display("FAIL single_bits got %b want %b", bits, exp);
      end
      tests_run++;
      if (uni !== 1'b1) begin
         tests_failed++; $display("FAIL single_bit_width got %b want 1", uni);
      end
      tests_run++;
      if (dclk != FRAME) begin
         tests_failed++; $display("FAIL single_done_time got %0d want %0d", dclk, FRAME);
      end
      tests_run++;
      if (dcnt != 1) begin
         tests_failed++; $display("FAIL single_done_count got %0d want 1", dcnt);
      end
      bad = 0;
      repeat (40) begin
         cyc();
         if (bus.tx_done !== 1'b0 || bus.tx !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL single_no_resend got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [NB-1:0] bits, exp0, expf;
      bit uni, tmo;
      int sw, dclk, dcnt, bad;
`ifdef UART_TX_PARITY_EN
      exp0 = {1'b1, 1'b0, 8'h00, 1'b0};
      expf = {1'b1, 1'b0, 8'hFF, 1'b0};
`else
      exp0 = {1'b1, 8'h00, 1'b0};
      expf = {1'b1, 8'hFF, 1'b0};
`endif
      tick_div = 1;
      bus.data = 8'h00;
      bus.not_empty = 1'b1;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      tests_run++;
      if (bits !== exp0 || uni !== 1'b1 || tmo !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_frame0 got %b uni=%b tmo=%b want %b", bits, uni, tmo, exp0);
      end
      tests_run++;
      if (dcnt != 1) begin
         tests_failed++; $display("FAIL b2b_done0 got %0d want 1", dcnt);
      end
      cyc();
      tests_run++;
      if (bus.tx_done !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_done_width got %b want 0", bus.tx_done);
      end
      bus.data = 8'hFF;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      bus.not_empty = 1'b0;
      tests_run++;
      if (bits !== expf || uni !== 1'b1 || tmo !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_frame1 got %b uni=%b tmo=%b want %b", bits, uni, tmo, expf);
      end
      tests_run++;
      if (sw + 1 != HOLDOFF + 1) begin
         tests_failed++; $display("FAIL b2b_gap got %0d want %0d", sw + 1, HOLDOFF + 1);
      end
      tests_run++;
      if (dcnt != 1) begin
         tests_failed++; $display("FAIL b2b_done1 got %0d want 1", dcnt);
      end
      bad = 0;
      repeat (60) begin
         cyc();
         if (bus.tx_done !== 1'b0 || bus.tx !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0 || bus.busy !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_no_third got %0d bad busy=%b want 0 0", bad, bus.busy);
      end
   endtask

   task automatic test_tick_gating();
      logic [NB-1:0] bits, exp;
      bit uni, tmo;
      int sw, dclk, dcnt;
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, 1'b0, 8'h96, 1'b0};
`else
      exp = {1'b1, 8'h96, 1'b0};
`endif
      tick_div = 16;
      tick_cnt = 0;
      stall_start = cyc_n + 800;
      stall_len = 100;
      bus.data = 8'h96;
      bus.not_empty = 1'b1;
      ne_pulse = 1'b1;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      stall_len = 0;
      tick_div = 1;
      tests_run++;
      if (tmo !== 1'b0) begin
         tests_failed++; $display("FAIL gating_timeout got %b want 0", tmo);
      end
      tests_run++;
      if (bits !== exp) begin
         tests_failed++; $display("FAIL gating_bits got %b want %b", bits, exp);
      end
      tests_run++;
      if (uni !== 1'b1) begin
         tests_failed++; $display("FAIL gating_stall_hold got %b want 1", uni);
      end
      tests_run++;
      if (dcnt != 1) begin
         tests_failed++; $display("FAIL gating_done_count got %0d want 1", dcnt);
      end
      repeat (10) cyc();
   endtask

   task automatic test_input_churn();
      logic [NB-1:0] bits, exp;
      bit uni, tmo;
      int sw, dclk, dcnt;
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, 1'b0, 8'h3C, 1'b0};
`else
      exp = {1'b1, 8'h3C, 1'b0};
`endif
      tick_div = 1;
      bus.data = 8'h3C;
      bus.not_empty = 1'b1;
      churn = 1'b1;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      churn = 1'b0;
      bus.not_empty = 1'b0;
      tests_run++;
      if (bits !== exp || uni !== 1'b1 || tmo !== 1'b0) begin
         tests_failed++; $display("FAIL churn_bits got %b uni=%b tmo=%b want %b", bits, uni, tmo, exp);
      end
      tests_run++;
      if (dclk != FRAME || dcnt != 1) begin
         tests_failed++; $display("FAIL churn_done got t=%0d n=%0d want %0d 1", dclk, dcnt, FRAME);
      end
      repeat (10) cyc();
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [NB-1:0] bits;
      bit uni, tmo;
      int sw, dclk, dcnt;
      tick_div = 1;
      bus.data = 8'hA5;
      bus.not_empty = 1'b1;
      ne_pulse = 1'b1;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      tests_run++;
      if (bits[DATA_BITS+1] !== 1'b0 || tmo !== 1'b0) begin
         tests_failed++; $display("FAIL parity_a5 got %b want 0", bits[DATA_BITS+1]);
      end
      tests_run++;
      if (dclk != 176) begin
         tests_failed++; $display("FAIL parity_a5_time got %0d want 176", dclk);
      end
      repeat (10) cyc();
      bus.data = 8'h07;
      bus.not_empty = 1'b1;
      ne_pulse = 1'b1;
      rx_frame(bits, uni, sw, dclk, dcnt, tmo);
      tests_run++;
      if (bits !== {1'b1, 1'b1, 8'h07, 1'b0} || uni !== 1'b1) begin
         tests_failed++; $display("FAIL parity_07 got %b want %b", bits, {1'b1, 1'b1, 8'h07, 1'b0});
      end
      tests_run++;
      if (dclk != 176) begin
         tests_failed++; $display("FAIL parity_07_time got %0d want 176", dclk);
      end
      repeat (10) cyc();
   endtask
`endif

   initial begin
      #800000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_tick_gating();
      test_input_churn();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
